// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: decodes load/store, sequences SRAM cycles with
// wait states, serves the memory-mapped UART registers and stalls the pipeline.
module mem_access_ctrl #(
  parameter int              DATA_W         = 16,
  parameter int              RAM_ADDR_W     = 18,
  parameter int              WAIT_CYCLES    = 2,
  parameter int              UART_PULSE     = 2,
  parameter logic [15:0]     UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0]     UART_STAT_ADDR = 16'hBF01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           instr,
  input  logic                  valid,
  input  logic [15:0]           addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [1:0]            mem_op,
  output logic [DATA_W-1:0]     rdata,
  output logic                  stall,
  output logic                  done,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_dout,
  input  logic [DATA_W-1:0]     ram_din,
  output logic                  ram_data_oe,
  output logic                  ram_ce_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n,
  output logic                  uart_rdn,
  output logic                  uart_wrn,
  input  logic                  uart_data_ready,
  input  logic                  uart_tbre,
  input  logic                  uart_tsre
);

  typedef enum logic [2:0] {
    IDLE, RAM_RD, RAM_WR, UART_RD, UART_WR, FINISH
  } state_t;

  localparam logic [3:0] RAM_LAST  = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] UART_LAST = 4'(UART_PULSE - 1);

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [DATA_W-1:0]     rdata_nxt, dout_nxt;
  logic [RAM_ADDR_W-1:0] addr_nxt;
  logic                  ce_n_nxt, oe_n_nxt, we_n_nxt, doe_nxt, rdn_nxt, wrn_nxt;
  logic                  done_nxt;
  logic                  accept, is_read, hit_data, hit_stat;
  logic                  unused_instr;

  assign unused_instr = ^instr[10:0];

  always_comb begin
    case (instr[15:11])
      5'b10010, 5'b10011: mem_op = 2'b01;
      5'b11010, 5'b11011: mem_op = 2'b10;
      default:            mem_op = 2'b11;
    endcase
  end

  assign accept   = valid && (mem_op != 2'b11);
  assign is_read  = (mem_op == 2'b01);
  assign hit_data = (addr == UART_DATA_ADDR);
  assign hit_stat = (addr == UART_STAT_ADDR);

  // Stall is combinational on the accept cycle so the pipeline freezes at once.
  assign stall = (state == IDLE) ? accept : (state != FINISH);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rdata_nxt = rdata;
    addr_nxt  = ram_addr;
    dout_nxt  = ram_dout;
    ce_n_nxt  = 1'b1;
    oe_n_nxt  = 1'b1;
    we_n_nxt  = 1'b1;
    doe_nxt   = 1'b0;
    rdn_nxt   = 1'b1;
    wrn_nxt   = 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          addr_nxt = RAM_ADDR_W'(addr);
          dout_nxt = wdata;
          cnt_nxt  = '0;
          if (is_read) begin
            if (hit_data) begin
              state_nxt = UART_RD;
              rdn_nxt   = 1'b0;
            end else if (hit_stat) begin
              state_nxt = FINISH;
              rdata_nxt = DATA_W'({uart_data_ready, uart_tbre & uart_tsre});
            end else begin
              state_nxt = RAM_RD;
              ce_n_nxt  = 1'b0;
              oe_n_nxt  = 1'b0;
            end
          end else begin
            if (hit_data) begin
              state_nxt = UART_WR;
              wrn_nxt   = 1'b0;
              doe_nxt   = 1'b1;
            end else if (hit_stat) begin
              state_nxt = FINISH;
            end else begin
              state_nxt = RAM_WR;
              ce_n_nxt  = 1'b0;
              we_n_nxt  = 1'b0;
              doe_nxt   = 1'b1;
            end
          end
        end
      end
      RAM_RD: begin
        if (cnt == RAM_LAST) begin
          rdata_nxt = ram_din;
          state_nxt = FINISH;
        end else begin
          cnt_nxt  = cnt + 4'd1;
          ce_n_nxt = 1'b0;
          oe_n_nxt = 1'b0;
        end
      end
      RAM_WR: begin
        if (cnt == RAM_LAST) begin
          state_nxt = FINISH;
        end else begin
          cnt_nxt  = cnt + 4'd1;
          ce_n_nxt = 1'b0;
          doe_nxt  = 1'b1;
          // The final write cycle releases we_n while data is still driven (hold).
          we_n_nxt = (cnt_nxt == RAM_LAST);
        end
      end
      UART_RD: begin
        if (cnt == UART_LAST) begin
          rdata_nxt = DATA_W'(ram_din[7:0]);
          state_nxt = FINISH;
        end else begin
          cnt_nxt = cnt + 4'd1;
          rdn_nxt = 1'b0;
        end
      end
      UART_WR: begin
        if (cnt == UART_LAST) begin
          state_nxt = FINISH;
        end else begin
          cnt_nxt = cnt + 4'd1;
          wrn_nxt = 1'b0;
          doe_nxt = 1'b1;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    done_nxt = (state_nxt == FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rdata       <= '0;
      done        <= 1'b0;
      ram_addr    <= '0;
      ram_dout    <= '0;
      ram_ce_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      ram_data_oe <= 1'b0;
      uart_rdn    <= 1'b1;
      uart_wrn    <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rdata       <= rdata_nxt;
      done        <= done_nxt;
      ram_addr    <= addr_nxt;
      ram_dout    <= dout_nxt;
      ram_ce_n    <= ce_n_nxt;
      ram_oe_n    <= oe_n_nxt;
      ram_we_n    <= we_n_nxt;
      ram_data_oe <= doe_nxt;
      uart_rdn    <= rdn_nxt;
      uart_wrn    <= wrn_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a table of single accesses with expected
// strobe counts and results, plus reset-abort and back-to-back sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr, addr, wdata, ram_din;
  logic        valid, uart_data_ready, uart_tbre, uart_tsre;
  logic [1:0]  mem_op;
  logic [15:0] rdata, ram_dout;
  logic [17:0] ram_addr;
  logic        stall, done, ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .valid(valid), .addr(addr), .wdata(wdata),
    .mem_op(mem_op), .rdata(rdata), .stall(stall), .done(done),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din),
    .ram_data_oe(ram_data_oe), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n), .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
    .uart_data_ready(uart_data_ready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic        valid;
    logic [15:0] addr, wdata, din;
    logic        dr, tbre, tsre;
    logic [1:0]  op;
    int          stall_n, done_at, ce_n, oe_n, we_n, doe_n, rdn_n, wrn_n;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[13];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] i, input logic v, input logic [15:0] a,
                              input logic [15:0] w, input logic [15:0] d,
                              input logic [2:0] u, input logic [1:0] op,
                              input int st, input int da, input int ce, input int oe,
                              input int we, input int doe, input int rdn, input int wrn,
                              input logic [15:0] rd);
    vec_t r;
    r.instr = i; r.valid = v; r.addr = a; r.wdata = w; r.din = d;
    r.dr = u[2]; r.tbre = u[1]; r.tsre = u[0]; r.op = op;
    r.stall_n = st; r.done_at = da; r.ce_n = ce; r.oe_n = oe; r.we_n = we;
    r.doe_n = doe; r.rdn_n = rdn; r.wrn_n = wrn; r.rdata = rd;
    return r;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int stall_c, ce_c, oe_c, we_c, doe_c, rdn_c, wrn_c, done_at;
    logic last_we;
    logic [15:0] dout_seen, rdata_seen;
    logic [17:0] addr_seen;
    stall_c = 0; ce_c = 0; oe_c = 0; we_c = 0; doe_c = 0; rdn_c = 0; wrn_c = 0;
    done_at = -1; last_we = 1'b0; dout_seen = '0; rdata_seen = '0; addr_seen = '0;
    @(negedge clk);
    instr = v.instr; valid = v.valid; addr = v.addr; wdata = v.wdata; ram_din = v.din;
    uart_data_ready = v.dr; uart_tbre = v.tbre; uart_tsre = v.tsre;
    #1;
    chk("mem_op", idx, 32'(mem_op), 32'(v.op));
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (stall) stall_c++;
      if (!ram_ce_n) begin ce_c++; last_we = ram_we_n; end
      if (!ram_oe_n) oe_c++;
      if (!ram_we_n) we_c++;
      if (ram_data_oe) begin doe_c++; dout_seen = ram_dout; end
      if (!uart_rdn) rdn_c++;
      if (!uart_wrn) wrn_c++;
      if (done) begin
        done_at = c; addr_seen = ram_addr; rdata_seen = rdata;
        break;
      end
      if (v.done_at < 0 && c == 3) break;
      if (c == 0) begin
        @(posedge clk); #1;
        valid = 1'b0; addr = 16'h5555; wdata = 16'hAAAA;
      end
    end
    chk("stall_cycles", idx, 32'(stall_c), 32'(v.stall_n));
    chk("done_cycle", idx, 32'(done_at), 32'(v.done_at));
    chk("ce_low", idx, 32'(ce_c), 32'(v.ce_n));
    chk("oe_low", idx, 32'(oe_c), 32'(v.oe_n));
    chk("we_low", idx, 32'(we_c), 32'(v.we_n));
    chk("data_oe", idx, 32'(doe_c), 32'(v.doe_n));
    chk("uart_rdn_low", idx, 32'(rdn_c), 32'(v.rdn_n));
    chk("uart_wrn_low", idx, 32'(wrn_c), 32'(v.wrn_n));
    if (v.done_at > 0) begin
      chk("rdata", idx, 32'(rdata_seen), 32'(v.rdata));
      chk("ram_addr", idx, 32'(addr_seen), 32'({2'b00, v.addr}));
    end else begin
      chk("rdata_kept", idx, 32'(rdata), 32'(v.rdata));
    end
    if (v.doe_n > 0) chk("ram_dout", idx, 32'(dout_seen), 32'(v.wdata));
    if (v.we_n > 0) chk("we_hold", idx, 32'(last_we), 32'd1);
    @(negedge clk);
    chk("idle_after", idx, 32'({done, stall}), 32'd0);
  endtask

  initial begin
    logic [9:0] done_v, stall_v;
    rst = 1'b1; valid = 1'b0; instr = '0; addr = '0; wdata = '0; ram_din = '0;
    uart_data_ready = 1'b0; uart_tbre = 1'b0; uart_tsre = 1'b0;

    vecs[0]  = mk(16'h9800, 1, 16'h0040, 16'h0000, 16'hBEEF, 3'b000, 2'b01, 3, 3, 2, 2, 0, 0, 0, 0, 16'hBEEF);
    vecs[1]  = mk(16'hD800, 1, 16'h0100, 16'h1234, 16'h0000, 3'b000, 2'b10, 3, 3, 2, 0, 1, 2, 0, 0, 16'hBEEF);
    vecs[2]  = mk(16'h9800, 1, 16'hBF01, 16'h0000, 16'hFFFF, 3'b110, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0002);
    vecs[3]  = mk(16'hD800, 1, 16'hBF00, 16'h0041, 16'h0000, 3'b000, 2'b10, 3, 3, 0, 0, 0, 2, 0, 2, 16'h0002);
    vecs[4]  = mk(16'h4800, 1, 16'h0040, 16'h0000, 16'h0000, 3'b000, 2'b11, 0, -1, 0, 0, 0, 0, 0, 0, 16'h0002);
    vecs[5]  = mk(16'h9000, 1, 16'hBF00, 16'h0000, 16'h12A5, 3'b000, 2'b01, 3, 3, 0, 0, 0, 0, 2, 0, 16'h00A5);
    vecs[6]  = mk(16'hD000, 1, 16'hBF01, 16'hFFFF, 16'h0000, 3'b111, 2'b10, 1, 1, 0, 0, 0, 0, 0, 0, 16'h00A5);
    vecs[7]  = mk(16'h9F00, 1, 16'hFFFF, 16'h0000, 16'h5A5A, 3'b000, 2'b01, 3, 3, 2, 2, 0, 0, 0, 0, 16'h5A5A);
    vecs[8]  = mk(16'hDF00, 1, 16'h8000, 16'hABCD, 16'h0000, 3'b000, 2'b10, 3, 3, 2, 0, 1, 2, 0, 0, 16'h5A5A);
    vecs[9]  = mk(16'h9800, 1, 16'hBF01, 16'h0000, 16'h0000, 3'b011, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0001);
    vecs[10] = mk(16'h9800, 0, 16'h0010, 16'h0000, 16'h7777, 3'b000, 2'b01, 0, -1, 0, 0, 0, 0, 0, 0, 16'h0001);
    vecs[11] = mk(16'hA000, 1, 16'h0010, 16'h0000, 16'h7777, 3'b000, 2'b11, 0, -1, 0, 0, 0, 0, 0, 0, 16'h0001);
    vecs[12] = mk(16'h9800, 1, 16'hBF01, 16'h0000, 16'h0000, 3'b111, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0, 16'h0003);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", 0, 32'({ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe, uart_rdn, uart_wrn}), 32'b111011);
    chk("rst_rdata", 0, 32'(rdata), 32'd0);
    chk("rst_done_stall", 0, 32'({done, stall}), 32'd0);
    chk("rst_addr_dout", 0, 32'({ram_addr, ram_dout}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Reset during the second RAM_RD cycle aborts the access
    @(negedge clk);
    instr = 16'h9800; valid = 1'b1; addr = 16'h0200; ram_din = 16'h7777;
    @(posedge clk); #1 valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_read", 100, 32'(ram_oe_n), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_strobes", 100, 32'({ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe, uart_rdn, uart_wrn}), 32'b111011);
    chk("abort_rdata", 100, 32'(rdata), 32'd0);
    chk("abort_done_stall", 100, 32'({done, stall}), 32'd0);
    run_vec(101, mk(16'h9800, 1, 16'h0040, 16'h0000, 16'hC0DE, 3'b000, 2'b01, 3, 3, 2, 2, 0, 0, 0, 0, 16'hC0DE));

    // Back-to-back loads with valid held: one stall-free gap on the FINISH cycle
    @(negedge clk);
    instr = 16'h9800; valid = 1'b1; addr = 16'h0300; ram_din = 16'h2222;
    #1;
    done_v = '0; stall_v = '0;
    for (int c = 0; c < 10; c++) begin
      done_v[c] = done; stall_v[c] = stall;
      if (c == 4) begin @(posedge clk); #1 valid = 1'b0; end
      @(negedge clk);
    end
    chk("b2b_done", 200, 32'(done_v), 32'(10'b0010001000));
    chk("b2b_stall", 200, 32'(stall_v), 32'(10'b0001110111));
    chk("b2b_rdata", 200, 32'(rdata), 32'h2222);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle MEM-stage access controller for the 16-bit CPU.
- Decodes the MEM-stage instruction into read, write or none, using the same 2-bit encoding the pipeline already uses.
- Sequences SRAM accesses with a configurable number of wait states, and serves memory-mapped UART data/status addresses.
- Stalls the pipeline until each access completes.

Parameters:
- DATA_W, 16, data bus width.
- RAM_ADDR_W, 18, physical SRAM address width; the CPU address is zero-extended to this width.
- WAIT_CYCLES, 2, SRAM access cycles, legal range 2..15.
- UART_PULSE, 2, cycles uart_rdn/uart_wrn are held low, legal range 1..15.
- UART_DATA_ADDR, 16'hBF00, UART data register address.
- UART_STAT_ADDR, 16'hBF01, UART status register address.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- instr  in  16  MEM-stage instruction
- valid  in  1  MEM-stage instruction valid
- addr  in  16  effective address
- wdata  in  DATA_W  store data
- mem_op  out  2  01 read, 10 write, 11 none (combinational)
- rdata  out  DATA_W  load result (registered)
- stall  out  1  hold the pipeline
- done  out  1  one-cycle completion pulse
- ram_addr  out  RAM_ADDR_W  SRAM address
- ram_dout  out  DATA_W  SRAM write data
- ram_din  in  DATA_W  SRAM read data
- ram_data_oe  out  1  drive the SRAM data bus
- ram_ce_n  out  1  SRAM chip enable, active low
- ram_oe_n  out  1  SRAM output enable, active low
- ram_we_n  out  1  SRAM write enable, active low
- uart_rdn  out  1  UART read strobe, active low
- uart_wrn  out  1  UART write strobe, active low
- uart_data_ready  in  1  UART receive data available
- uart_tbre  in  1  UART transmit buffer empty
- uart_tsre  in  1  UART transmit shift register empty

Behaviour:
- Decode of instr[15:11]:
  - 10010 / 10011 -> read (01).
  - 11010 / 11011 -> write (10).
  - Anything else -> 11.
  - mem_op is purely combinational and ignores valid.
- Reset: state=IDLE, counter=0, rdata=0, done=0, stall=0, ram_ce_n=ram_oe_n=ram_we_n=1, ram_data_oe=0, uart_rdn=uart_wrn=1, ram_addr=0, ram_dout=0. Reset mid-access aborts the access; all strobes are inactive after that same edge.
- States: IDLE, RAM_RD, RAM_WR, UART_RD, UART_WR, FINISH.
- IDLE accepts when valid && mem_op!=11. On acceptance, latch addr and wdata, then go to:
  - read, addr==UART_DATA_ADDR -> UART_RD
  - read, addr==UART_STAT_ADDR -> FINISH; rdata = {zeros, uart_data_ready, uart_tbre&uart_tsre} (bit1 = data_ready, bit0 = tx ready)
  - write, addr==UART_DATA_ADDR -> UART_WR
  - write, addr==UART_STAT_ADDR -> FINISH with no side effect
  - other read -> RAM_RD
  - other write -> RAM_WR
- RAM_RD: ce_n=0, oe_n=0 for exactly WAIT_CYCLES cycles. rdata captures ram_din on the last cycle, then go to FINISH.
- RAM_WR: ce_n=0, ram_data_oe=1, ram_dout=latched wdata for WAIT_CYCLES cycles. we_n=0 on all but the last cycle; the last cycle is data hold. Then go to FINISH.
- UART_RD: uart_rdn=0 for UART_PULSE cycles. rdata captures ram_din[7:0] zero-extended on the last cycle, then go to FINISH.
- UART_WR: ram_data_oe=1 with ram_dout=wdata throughout. uart_wrn=0 for UART_PULSE cycles, then go to FINISH.
- ce_n is held high during UART states.
- FINISH: done=1 for one cycle, all strobes inactive, stall=0. Always returns to IDLE; it never accepts a new access.
- stall:
  - Combinational 1 in IDLE when the accept condition is true.
  - 1 in every state except IDLE and FINISH.
  - 0 otherwise.
- Latency from acceptance edge to done: RAM = WAIT_CYCLES+1 cycles, UART data = UART_PULSE+1, status = 1.
- Strobes and ram_addr/ram_dout are registered outputs, so they are glitch-free.
- ram_addr = zero-extended latched addr, held from acceptance through FINISH.
- rdata holds its value until the next read completes.
- Writes never alter rdata.
- Inputs are ignored outside IDLE; addr/wdata changes mid-access have no effect.
- Back-to-back accesses: the pipeline advances on the FINISH cycle. The next instruction is evaluated in IDLE the following cycle, giving a one-cycle gap with stall=0.

Test Plan:
- Reset, then instr=16'h9800 (LW), valid=1, addr=16'h0040, ram_din=16'hBEEF, WAIT_CYCLES=2 -> mem_op=01; stall high for 3 cycles; oe_n low for 2 cycles; ram_addr=18'h00040; done on cycle 3; rdata=16'hBEEF.
- instr=16'hD800 (SW), addr=16'h0100, wdata=16'h1234 -> we_n low for 1 cycle then high for 1 hold cycle; ram_data_oe high for 2 cycles; ram_dout=16'h1234; done after 3 cycles; rdata unchanged.
- Read addr=16'hBF01 with data_ready=1, tbre=1, tsre=0 -> rdata=16'h0002; stall for 1 cycle; no SRAM or UART strobe.
- SW to 16'hBF00, wdata=16'h0041, UART_PULSE=2 -> uart_wrn low for 2 cycles with ram_dout=16'h0041; ce_n stays 1; done on the 3rd cycle.
- instr=16'h4800 (ADDIU) with valid=1 -> mem_op=11; stall=0; no strobes; done=0.
- Assert rst in the second RAM_RD cycle -> after that edge all strobes inactive, rdata=0, state IDLE; the next LW completes normally.
